alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, multi-cycle successor to the combinational datapath ALU. Accepts one operation per
//  start/ready handshake. Single-cycle ops complete in 1 clock. DADD, count-based shifts/rotates and MUL
//  iterate over several clocks. Result and PSW are registered. Sits between the operand fetch stage and
//  register-file/PSW writeback in the CPU core.
// PARAMETERS
//  WIDTH  16  datapath width; multiple of 8, >=16; byte (.b) ops always act on bits [7:0]
//  CNTW   $clog2(WIDTH)+1 (localparam)  width of the iteration counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start_i    in   1      request; accepted on a rising edge where start_i & ready_o
//  ready_o    out  1      1 when state != RUN
//  op_i       in   4      0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 XOR, 6 AND, 7 OR, 8 DADD, 9 SRA, 10 RRC, 11 MUL
//  bw_i       in   1      1 = byte op: low 8 bits only, res[WIDTH-1:8] = a[WIDTH-1:8]
//  upd_psw_i  in   1      1 = flags are written; 0 = psw_o gets captured psw_i unchanged
//  a_i        in   WIDTH  dst operand
//  b_i        in   WIDTH  src operand; for SRA/RRC this is the shift count
//  psw_i      in   5      {V,S,N,Z,C}; C is the carry-in
//  res_o      out  WIDTH  registered result; held until the next completion
//  psw_o      out  5      registered PSW; held until the next completion
//  done_o     out  1      one-cycle pulse; res_o/psw_o are valid in that cycle
// BEHAVIOUR
//  Reset (async): state=IDLE, res_o=0, psw_o=0, done_o=0, ready_o=1. Counter and operand regs cleared.
//  Accept: on an accepting edge, a_i/b_i/op_i/bw_i/upd_psw_i/psw_i are captured. The op then uses captured values only.
//  Ignored start: start_i while ready_o=0 has no effect.
//  FSM: IDLE --start, k=0--> DONE; IDLE --start, k>0--> RUN.
//       RUN: one iteration per clock; goes to DONE after the k-th iteration.
//       DONE (done_o=1, ready_o=1): --start--> accept (back-to-back allowed); else --> IDLE.
//  Latency: start edge to done_o = 1+k clocks. n = 8 if bw_i else WIDTH.
//    Single-cycle ops: k=0.
//    DADD: k = n/4 (one BCD nibble per clock, LSB nibble first, decimal carry chained, carry-in = C).
//    SRA/RRC: k = min(b, n). k=0 gives res=a and flags computed on a.
//    MUL: k = n (shift-add, one multiplier bit per clock).
//  Arithmetic (mod 2^n):
//    ADD a+b; ADDC a+b+C; SUB a+~b+1; SUBC a+~b+C.
//    CMP as SUB but res_o=a.
//    C = carry out of bit n-1 (for SUB/SUBC/CMP, C=1 means no borrow).
//    V = operands' signs agree (after ~b for subtracts) and the result sign differs.
//    N = res[n-1]; Z = (res[n-1:0]==0).
//  Logic (XOR/AND/OR): N,Z updated; C,V unchanged.
//  DADD: C = final decimal carry; N,Z from result; V unchanged. Nibbles >9 in inputs: add then correct by +6; no error flag.
//  SRA: arithmetic right shift, one bit per clock. C = last bit shifted out; V=0; N,Z updated.
//  RRC: rotate right through C, one bit per clock. C = last bit out; V=0; N,Z updated.
//  MUL: unsigned a*b, low n bits to res. C=V=1 iff high n bits of the product != 0; N,Z updated.
//  Byte ops: flags from bit 7 / low byte.
//  S (psw bit 3): always passed through from captured psw_i.
//  upd_psw_i=0: psw_o = captured psw_i for every op, including C from DADD/shift.
//  Illegal op (12-15, or 11 without the macro): k=0, res_o=a, psw_o=captured psw_i.
//  Reset mid-RUN: op abandoned; no done_o; all outputs return to reset values.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: MUL (op 11) and its multiplicand/product registers are built.
//  ALU_SEQ_MUL_EN undefined: op 11 is illegal (see above); no multiplier logic.
// TESTING
//  1 ADD, W=16: a=7FFF, b=0001, upd=1 -> done_o 1 clk after start, res=8000, V=1 N=1 Z=0 C=0.
//  2 DADD: a=0999, b=0001, C=0 -> res=1000, C=0, latency 5.
//    DADD: a=9999, b=0001 -> res=0000, C=1, Z=1.
//  3 SRA.b: a=1284, b=3 -> res=12F0, C=1, N=1, latency 4.
//    RRC: a=0001, C=1, b=2 -> res=C000, C=0, latency 3.
//  4 SUB: a=0003, b=0005 -> res=FFFE, C=0, N=1.
//    CMP: same operands -> res=0003, same flags.
//    upd=0 -> psw_o = psw_i.
//  5 MUL with ALU_SEQ_MUL_EN: a=0100, b=0100 -> res=0000, C=V=1, Z=1, latency 17.
//    MUL without the macro -> res=0100, psw unchanged, latency 1.
//  6 DADD started, then start_i pulsed in RUN -> ignored.
//    rst_n=0 mid-RUN -> no done_o, res_o=0, psw_o=0, ready_o=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result handshake between operand fetch and alu_seq.
`timescale 1ns/1ps
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             start_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic             bw_i;
  logic             upd_psw_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [4:0]       psw_i;
  logic [WIDTH-1:0] res_o;
  logic [4:0]       psw_o;
  logic             done_o;

  modport master (output start_i, op_i, bw_i, upd_psw_i, a_i, b_i, psw_i,
                  input  ready_o, res_o, psw_o, done_o);
  modport slave  (input  start_i, op_i, bw_i, upd_psw_i, a_i, b_i, psw_i,
                  output ready_o, res_o, psw_o, done_o);
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops finish on the accept edge, DADD/SRA/RRC/MUL iterate in RUN.
// ALU_SEQ_MUL_EN builds the shift-add multiplier (op 11); without it op 11 is illegal.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADDC = 4'd1, OP_SUB = 4'd2, OP_SUBC = 4'd3,
                         OP_CMP = 4'd4, OP_XOR = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7,
                         OP_DADD = 4'd8, OP_SRA = 4'd9, OP_RRC = 4'd10, OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc, b_q, res_q;
  logic [3:0]       op_q;
  logic             bw_q, upd_q, cy, done_q;
  logic [4:0]       psw_q, pswo_q;
  logic [CNTW-1:0]  cnt;

  // {V,S,N,Z,C}; S always passes through, uc/uv select which of C/V the op owns
  function automatic logic [4:0] mk_psw(input logic upd, input logic bw, input logic [4:0] p,
                                        input logic [WIDTH-1:0] fr, input logic c, input logic v,
                                        input logic uc, input logic uv);
    logic n, z;
    n = bw ? fr[7] : fr[WIDTH-1];
    z = bw ? (fr[7:0] == 8'd0) : (fr == '0);
    if (!upd) return p;
    return {uv ? v : p[4], p[3], n, z, uc ? c : p[0]};
  endfunction

  // ---- accept-edge path (single-cycle ops and iteration count) ----
  logic             sub, cin, ac, av, am, bm, rm;
  logic [WIDTH-1:0] bb, ar, lw, lr, sc_res;
  logic [WIDTH:0]   sw;
  logic [8:0]       sb;
  logic [4:0]       sc_psw;
  logic [CNTW-1:0]  nbits, shk, k;

  always_comb begin
    sub   = (bus.op_i == OP_SUB) || (bus.op_i == OP_SUBC) || (bus.op_i == OP_CMP);
    bb    = sub ? ~bus.b_i : bus.b_i;
    case (bus.op_i)
      OP_ADDC, OP_SUBC: cin = bus.psw_i[0];
      OP_SUB, OP_CMP:   cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sw = {1'b0, bus.a_i} + {1'b0, bb} + (WIDTH+1)'(cin);
    sb = {1'b0, bus.a_i[7:0]} + {1'b0, bb[7:0]} + 9'(cin);
    ar = bus.bw_i ? {bus.a_i[WIDTH-1:8], sb[7:0]} : sw[WIDTH-1:0];
    ac = bus.bw_i ? sb[8] : sw[WIDTH];
    am = bus.bw_i ? bus.a_i[7] : bus.a_i[WIDTH-1];
    bm = bus.bw_i ? bb[7] : bb[WIDTH-1];
    rm = bus.bw_i ? ar[7] : ar[WIDTH-1];
    av = (am == bm) && (rm != am);
    case (bus.op_i)
      OP_XOR:  lw = bus.a_i ^ bus.b_i;
      OP_AND:  lw = bus.a_i & bus.b_i;
      default: lw = bus.a_i | bus.b_i;
    endcase
    lr    = bus.bw_i ? {bus.a_i[WIDTH-1:8], lw[7:0]} : lw;
    nbits = bus.bw_i ? CNTW'(8) : CNTW'(WIDTH);
    shk   = (bus.b_i > WIDTH'(nbits)) ? nbits : CNTW'(bus.b_i);
    case (bus.op_i)
      OP_DADD:        k = nbits >> 2;
      OP_SRA, OP_RRC: k = shk;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:         k = nbits;
`endif
      default:        k = '0;
    endcase
    sc_res = bus.a_i;
    sc_psw = bus.psw_i;
    case (bus.op_i)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        sc_res = ar;
        sc_psw = mk_psw(bus.upd_psw_i, bus.bw_i, bus.psw_i, ar, ac, av, 1'b1, 1'b1);
      end
      OP_CMP: sc_psw = mk_psw(bus.upd_psw_i, bus.bw_i, bus.psw_i, ar, ac, av, 1'b1, 1'b1);
      OP_XOR, OP_AND, OP_OR: begin
        sc_res = lr;
        sc_psw = mk_psw(bus.upd_psw_i, bus.bw_i, bus.psw_i, lr, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      // zero-count shift: nothing shifted out, so C is left alone
      OP_SRA, OP_RRC:
        sc_psw = mk_psw(bus.upd_psw_i, bus.bw_i, bus.psw_i, bus.a_i, 1'b0, 1'b0, 1'b0, 1'b1);
      default: ;
    endcase
  end

  // ---- one iteration of the running op ----
  logic [WIDTH-1:0] acc_n, b_n;
  logic             cy_n, dc;
  logic [4:0]       t, fin_psw;
  logic [3:0]       dig;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand, prod, mcand_n, prod_n;
  logic               hi;
`endif

  always_comb begin
    acc_n   = acc;
    b_n     = b_q;
    cy_n    = cy;
    fin_psw = psw_q;
    t       = {1'b0, acc[3:0]} + {1'b0, b_q[3:0]} + 5'(cy);
    dc      = (t > 5'd9);
    dig     = dc ? (t[3:0] + 4'd6) : t[3:0];
`ifdef ALU_SEQ_MUL_EN
    mcand_n = mcand;
    prod_n  = prod;
    hi      = 1'b0;
`endif
    case (op_q)
      OP_DADD: begin
        // result nibbles enter at the top of the n-bit field while a/b shift down
        acc_n   = bw_q ? {acc[WIDTH-1:8], dig, acc[7:4]} : {dig, acc[WIDTH-1:4]};
        b_n     = b_q >> 4;
        cy_n    = dc;
        fin_psw = mk_psw(upd_q, bw_q, psw_q, acc_n, cy_n, 1'b0, 1'b1, 1'b0);
      end
      OP_SRA, OP_RRC: begin
        if (bw_q) acc_n = {acc[WIDTH-1:8], (op_q == OP_SRA) ? acc[7] : cy, acc[7:1]};
        else      acc_n = {(op_q == OP_SRA) ? acc[WIDTH-1] : cy, acc[WIDTH-1:1]};
        cy_n    = acc[0];
        fin_psw = mk_psw(upd_q, bw_q, psw_q, acc_n, cy_n, 1'b0, 1'b1, 1'b1);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        prod_n  = prod + (b_q[0] ? mcand : '0);
        mcand_n = mcand << 1;
        b_n     = b_q >> 1;
        acc_n   = bw_q ? {acc[WIDTH-1:8], prod_n[7:0]} : prod_n[WIDTH-1:0];
        hi      = bw_q ? (|prod_n[15:8]) : (|prod_n[2*WIDTH-1:WIDTH]);
        fin_psw = mk_psw(upd_q, bw_q, psw_q, acc_n, hi, hi, 1'b1, 1'b1);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      bw_q   <= 1'b0;
      upd_q  <= 1'b0;
      psw_q  <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      pswo_q <= '0;
      done_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= '0;
      prod   <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          acc <= acc_n;
          b_q <= b_n;
          cy  <= cy_n;
          cnt <= cnt - 1'b1;
`ifdef ALU_SEQ_MUL_EN
          mcand <= mcand_n;
          prod  <= prod_n;
`endif
          if (cnt == CNTW'(1)) begin
            res_q  <= acc_n;
            pswo_q <= fin_psw;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start_i) begin
            acc   <= bus.a_i;
            b_q   <= bus.b_i;
            op_q  <= bus.op_i;
            bw_q  <= bus.bw_i;
            upd_q <= bus.upd_psw_i;
            psw_q <= bus.psw_i;
            cy    <= bus.psw_i[0];
            cnt   <= k;
`ifdef ALU_SEQ_MUL_EN
            mcand <= bus.bw_i ? (2*WIDTH)'(bus.a_i[7:0]) : (2*WIDTH)'(bus.a_i);
            prod  <= '0;
`endif
            if (k == '0) begin
              res_q  <= sc_res;
              pswo_q <= sc_psw;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= RUN;
            end
          end
        end
      endcase
    end
  end

  assign bus.ready_o = (state != RUN);
  assign bus.res_o   = res_q;
  assign bus.psw_o   = pswo_q;
  assign bus.done_o  = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed vectors for alu_seq with a scoreboard queue checked by an independent done_o monitor.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0, failures = 0, cyc = 0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [4:0]   psw;
    int           lat;
    int           acc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every done_o pulse must match the oldest outstanding expectation
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && bus.done_o) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1 res=%0h expected no completion", bus.res_o);
      end else begin
        e = q.pop_front();
        chk({e.name, "_res"}, 32'(bus.res_o), 32'(e.res));
        chk({e.name, "_psw"}, 32'(bus.psw_o), 32'(e.psw));
        chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic bw, input logic upd,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] p);
    bus.op_i = op; bus.bw_i = bw; bus.upd_psw_i = upd;
    bus.a_i = a; bus.b_i = b; bus.psw_i = p;
    bus.start_i = 1'b1;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input string nm, input logic [3:0] op, input logic bw, input logic upd,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] p,
                       input logic [W-1:0] er, input logic [4:0] ep, input int lat);
    int t;
    exp_t e;
    t = 0;
    while (!bus.ready_o && t < 100) begin @(negedge clk); t++; end
    if (!bus.ready_o) begin
      checks++; failures++;
      $display("FAIL %s_ready: got ready_o=0 expected 1 within 100 cycles", nm);
    end
    drive(op, bw, upd, a, b, p);
    e.name = nm; e.res = er; e.psw = ep; e.lat = lat; e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending completions expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0; bus.op_i = '0; bus.bw_i = 1'b0; bus.upd_psw_i = 1'b0;
    bus.a_i = '0; bus.b_i = '0; bus.psw_i = '0;
    #1;
    chk("rst_res",   32'(bus.res_o),   32'h0);
    chk("rst_psw",   32'(bus.psw_o),   32'h0);
    chk("rst_ready", 32'(bus.ready_o), 32'h1);
    chk("rst_done",  32'(bus.done_o),  32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    //      name      op     bw    upd   a         b         psw       res       psw       lat
    issue("add_v",   4'd0,  1'b0, 1'b1, 16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 5'b10100, 1);
    issue("sub",     4'd2,  1'b0, 1'b1, 16'h0003, 16'h0005, 5'b00000, 16'hFFFE, 5'b00100, 1);
    issue("cmp",     4'd4,  1'b0, 1'b1, 16'h0003, 16'h0005, 5'b00000, 16'h0003, 5'b00100, 1);
    issue("sub_nou", 4'd2,  1'b0, 1'b0, 16'h0003, 16'h0005, 5'b01011, 16'hFFFE, 5'b01011, 1);
    issue("dadd1",   4'd8,  1'b0, 1'b1, 16'h0999, 16'h0001, 5'b00000, 16'h1000, 5'b00000, 5);
    issue("dadd2",   4'd8,  1'b0, 1'b1, 16'h9999, 16'h0001, 5'b00000, 16'h0000, 5'b00011, 5);
    issue("sra_b",   4'd9,  1'b1, 1'b1, 16'h1284, 16'h0003, 5'b00000, 16'h12F0, 5'b00101, 4);
    issue("rrc",     4'd10, 1'b0, 1'b1, 16'h0001, 16'h0002, 5'b00001, 16'hC000, 5'b00100, 3);
    issue("xor",     4'd5,  1'b0, 1'b1, 16'hF0F0, 16'hFF00, 5'b10001, 16'h0FF0, 5'b10001, 1);
    issue("and_b",   4'd6,  1'b1, 1'b1, 16'h12F0, 16'hFF0F, 5'b00000, 16'h1200, 5'b00010, 1);
    issue("addc_b",  4'd1,  1'b1, 1'b1, 16'h00FF, 16'h0000, 5'b00001, 16'h0000, 5'b00011, 1);
    issue("illegal", 4'd13, 1'b0, 1'b1, 16'hABCD, 16'h1234, 5'b10101, 16'hABCD, 5'b10101, 1);
    issue("sra_k0",  4'd9,  1'b0, 1'b1, 16'h8000, 16'h0000, 5'b00000, 16'h8000, 5'b00100, 1);
    issue("subc",    4'd3,  1'b0, 1'b1, 16'h0005, 16'h0003, 5'b00001, 16'h0002, 5'b00001, 1);
    issue("rrc_sat", 4'd10, 1'b0, 1'b1, 16'h0001, 16'h0014, 5'b00000, 16'h0002, 5'b00000, 17);
`ifdef ALU_SEQ_MUL_EN
    issue("mul",     4'd11, 1'b0, 1'b1, 16'h0100, 16'h0100, 5'b01000, 16'h0000, 5'b11011, 17);
`else
    issue("mul_ill", 4'd11, 1'b0, 1'b1, 16'h0100, 16'h0100, 5'b01000, 16'h0100, 5'b01000, 1);
`endif
    drain();

    // start pulsed while RUN must be ignored
    issue("dadd_ign", 4'd8, 1'b0, 1'b1, 16'h0999, 16'h0001, 5'b00000, 16'h1000, 5'b00000, 5);
    drive(4'd0, 1'b0, 1'b1, 16'h0001, 16'h0001, 5'b00000);
    @(negedge clk); bus.start_i = 1'b0;
    drain();

    // leave non-zero outputs, then reset in the middle of a DADD
    issue("add_pre", 4'd0, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 5'b10100, 1);
    drain();
    drive(4'd8, 1'b0, 1'b1, 16'h0999, 16'h0001, 5'b00000);
    @(negedge clk); bus.start_i = 1'b0;
    @(negedge clk);
    chk("run_ready", 32'(bus.ready_o), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mrst_res",   32'(bus.res_o),   32'h0);
    chk("mrst_psw",   32'(bus.psw_o),   32'h0);
    chk("mrst_ready", 32'(bus.ready_o), 32'h1);
    chk("mrst_done",  32'(bus.done_o),  32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_ready", 32'(bus.ready_o), 32'h1);
    chk("post_res",   32'(bus.res_o),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
